// File: rtl/w_cpu_io_cfg_switch_matrix.sv
// w_cpu_io_cfg_switch_matrix
//
// West-edge CPU_IO switch matrix. Every configurable output picks one of
// four sources through a 2-bit select and may be taken from a per-output
// flop instead of straight from the mux. Configuration is shifted serially
// into a shadow chain and only becomes active on an accepted commit.
//
// Ports
//   UserCLK, rst           clock (rising edge), async active-high reset
//   W1END, WW4END          single / quad hop inputs (fixed wiring only)
//   W2MID, W2END, W6END    double / hex hop inputs
//   OPA_O, OPB_O           CPU operand outputs
//   E1BEG, EE4BEG          fixed bit-reversed pass-through
//   E2BEG, E2BEGb, E6BEG   configurable east-going wires
//   RES_I                  configurable CPU result inputs (RES0..RES2)
//   CONFin, cfg_shift      serial config data and shift enable
//   CONFout                shadow chain tail
//   cfg_commit             request to move shadow into active
//   cfg_err, cfg_active    sticky commit rejection / config loaded flag
module w_cpu_io_cfg_switch_matrix #(
  parameter  int NUM_CH   = 4,
  localparam int NUM_OUT  = 10 * NUM_CH,
  localparam int CFG_BITS = 3 * NUM_OUT
) (
  input  logic                  UserCLK,
  input  logic                  rst,
  input  logic [3:0]            W1END,
  input  logic [2*NUM_CH-1:0]   W2MID,
  input  logic [2*NUM_CH-1:0]   W2END,
  input  logic [15:0]           WW4END,
  input  logic [3*NUM_CH-1:0]   W6END,
  input  logic [NUM_CH-1:0]     OPA_O,
  input  logic [NUM_CH-1:0]     OPB_O,
  output logic [3:0]            E1BEG,
  output logic [15:0]           EE4BEG,
  output logic [2*NUM_CH-1:0]   E2BEG,
  output logic [2*NUM_CH-1:0]   E2BEGb,
  output logic [3*NUM_CH-1:0]   E6BEG,
  output logic [3*NUM_CH-1:0]   RES_I,
  input  logic                  CONFin,
  input  logic                  cfg_shift,
  output logic                  CONFout,
  input  logic                  cfg_commit,
  output logic                  cfg_err,
  output logic                  cfg_active
);

  localparam int N     = NUM_CH;
  // count must hold CFG_BITS+1 so an over-long load is distinguishable
  localparam int CNT_W = $clog2(CFG_BITS + 2);

  logic [CFG_BITS-1:0] shadow;
  logic [CFG_BITS-1:0] active;
  logic [CNT_W-1:0]    count;
  logic [NUM_OUT-1:0]  mux_val;
  logic [NUM_OUT-1:0]  out_q;
  logic [NUM_OUT-1:0]  out_val;

  function automatic logic mux4(input logic [1:0] sel, input logic s0,
                                input logic s1, input logic s2);
    case (sel)
      2'd0:    return s0;
      2'd1:    return s1;
      2'd2:    return s2;
      default: return 1'b0;
    endcase
  endfunction

  // Output index k: E2BEG, E2BEGb, E6BEG, RES_I in that order.
  for (genvar i = 0; i < 2*N; i++) begin : g_e2
    assign mux_val[i] = mux4(active[3*i +: 2],
                             W2MID[2*N-1-i], OPB_O[i%N], OPA_O[i%N]);
    assign mux_val[2*N+i] = mux4(active[3*(2*N+i) +: 2],
                                 W2END[2*N-1-i], OPA_O[i%N], OPB_O[i%N]);
  end

  for (genvar i = 0; i < 3*N; i++) begin : g_e6_res
    assign mux_val[4*N+i] = mux4(active[3*(4*N+i) +: 2],
                                 OPA_O[i%N], OPB_O[i%N], W6END[3*N-1-i]);
    assign mux_val[7*N+i] = mux4(active[3*(7*N+i) +: 2],
                                 W6END[i], W2END[i%(2*N)], OPA_O[i%N]);
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign out_val[k] = active[3*k+2] ? out_q[k] : mux_val[k];
  end

  for (genvar i = 0; i < 4; i++) begin : g_e1
    assign E1BEG[i] = W1END[3-i];
  end

  for (genvar i = 0; i < 16; i++) begin : g_ee4
    assign EE4BEG[i] = WW4END[15-i];
  end

  assign E2BEG   = out_val[2*N-1:0];
  assign E2BEGb  = out_val[4*N-1:2*N];
  assign E6BEG   = out_val[7*N-1:4*N];
  assign RES_I   = out_val[10*N-1:7*N];
  assign CONFout = shadow[CFG_BITS-1];

  // Flops always track the mux so a later switch to registered mode
  // presents a value that is at most one cycle old.
  always_ff @(posedge UserCLK or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= mux_val;
  end

  // Commit wins over shift when both are requested in the same cycle.
  always_ff @(posedge UserCLK or posedge rst) begin
    if (rst) begin
      shadow     <= '0;
      active     <= '0;
      count      <= '0;
      cfg_err    <= 1'b0;
      cfg_active <= 1'b0;
    end else if (cfg_commit) begin
      count <= '0;
      if (count == CNT_W'(CFG_BITS)) begin
        active     <= shadow;
        cfg_active <= 1'b1;
        cfg_err    <= 1'b0;
      end else begin
        cfg_err <= 1'b1;
      end
    end else if (cfg_shift) begin
      shadow <= {shadow[CFG_BITS-2:0], CONFin};
      if (count != CNT_W'(CFG_BITS + 1)) count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_w_cpu_io_cfg_switch_matrix.sv
module tb_w_cpu_io_cfg_switch_matrix;
  localparam int N  = 4;
  localparam int NO = 10 * N;
  localparam int CB = 3 * NO;

  logic        UserCLK = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  W1END = '0;
  logic [7:0]  W2MID = '0, W2END = '0;
  logic [15:0] WW4END = '0;
  logic [11:0] W6END = '0;
  logic [3:0]  OPA_O = '0, OPB_O = '0;
  logic [3:0]  E1BEG;
  logic [15:0] EE4BEG;
  logic [7:0]  E2BEG, E2BEGb;
  logic [11:0] E6BEG, RES_I;
  logic        CONFin = 1'b0, cfg_shift = 1'b0, cfg_commit = 1'b0;
  logic        CONFout, cfg_err, cfg_active;

  w_cpu_io_cfg_switch_matrix #(.NUM_CH(N)) dut (
    .UserCLK(UserCLK), .rst(rst), .W1END(W1END), .W2MID(W2MID), .W2END(W2END),
    .WW4END(WW4END), .W6END(W6END), .OPA_O(OPA_O), .OPB_O(OPB_O),
    .E1BEG(E1BEG), .EE4BEG(EE4BEG), .E2BEG(E2BEG), .E2BEGb(E2BEGb),
    .E6BEG(E6BEG), .RES_I(RES_I), .CONFin(CONFin), .cfg_shift(cfg_shift),
    .CONFout(CONFout), .cfg_commit(cfg_commit), .cfg_err(cfg_err),
    .cfg_active(cfg_active)
  );

  always #5 UserCLK = ~UserCLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: shadow as a FIFO of bits (front = chain tail),
  // active config as a per-output field array.
  bit          m_sh[$];
  int          m_count;
  logic [2:0]  m_field[NO];
  logic [NO-1:0] m_q;
  logic        m_err, m_act;
  logic [2:0]  cfg_fields[NO];

  logic [NO-1:0] dut_outs;
  logic [19:0]   dut_fixed;
  assign dut_outs  = {RES_I, E6BEG, E2BEGb, E2BEG};
  assign dut_fixed = {EE4BEG, E1BEG};

  function automatic logic src_bit(int k, logic [1:0] sel);
    int i;
    logic r;
    r = 1'b0;
    if (k < 2*N) begin
      i = k;
      case (sel)
        2'd0: r = W2MID[2*N-1-i];
        2'd1: r = OPB_O[i%N];
        2'd2: r = OPA_O[i%N];
        default: r = 1'b0;
      endcase
    end else if (k < 4*N) begin
      i = k - 2*N;
      case (sel)
        2'd0: r = W2END[2*N-1-i];
        2'd1: r = OPA_O[i%N];
        2'd2: r = OPB_O[i%N];
        default: r = 1'b0;
      endcase
    end else if (k < 7*N) begin
      i = k - 4*N;
      case (sel)
        2'd0: r = OPA_O[i%N];
        2'd1: r = OPB_O[i%N];
        2'd2: r = W6END[3*N-1-i];
        default: r = 1'b0;
      endcase
    end else begin
      i = k - 7*N;
      case (sel)
        2'd0: r = W6END[i];
        2'd1: r = W2END[i%(2*N)];
        2'd2: r = OPA_O[i%N];
        default: r = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [NO-1:0] exp_outs();
    logic [NO-1:0] r;
    for (int k = 0; k < NO; k++)
      r[k] = m_field[k][2] ? m_q[k] : src_bit(k, m_field[k][1:0]);
    return r;
  endfunction

  function automatic logic [19:0] exp_fixed();
    logic [19:0] r;
    for (int i = 0; i < 4; i++)  r[i]   = W1END[3-i];
    for (int i = 0; i < 16; i++) r[4+i] = WW4END[15-i];
    return r;
  endfunction

  task automatic model_reset();
    m_sh.delete();
    for (int j = 0; j < CB; j++) m_sh.push_back(1'b0);
    m_count = 0;
    for (int k = 0; k < NO; k++) m_field[k] = 3'b000;
    m_q = '0;
    m_err = 1'b0;
    m_act = 1'b0;
  endtask

  task automatic tick();
    logic [NO-1:0] q_n;
    logic c, s, d;
    bit dummy;
    for (int k = 0; k < NO; k++) q_n[k] = src_bit(k, m_field[k][1:0]);
    c = cfg_commit; s = cfg_shift; d = CONFin;
    @(posedge UserCLK);
    m_q = q_n;
    if (c) begin
      if (m_count == CB) begin
        for (int k = 0; k < NO; k++)
          for (int b = 0; b < 3; b++) m_field[k][b] = m_sh[CB-1-(3*k+b)];
        m_act = 1'b1;
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_count = 0;
    end else if (s) begin
      dummy = m_sh.pop_front();
      m_sh.push_back(d);
      if (m_count < CB + 1) m_count++;
    end
    #1;
  endtask

  task automatic rand_inputs();
    W1END  = 4'($urandom);
    W2MID  = 8'($urandom);
    W2END  = 8'($urandom);
    WW4END = 16'($urandom);
    W6END  = 12'($urandom);
    OPA_O  = 4'($urandom);
    OPB_O  = 4'($urandom);
  endtask

  task automatic shift_stream(int n);
    int b;
    for (int j = 0; j < n; j++) begin
      b = (CB - 1 - j) % CB;
      CONFin = cfg_fields[b/3][b%3];
      cfg_shift = 1'b1;
      tick();
    end
    cfg_shift = 1'b0;
    CONFin = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic clear_fields();
    for (int k = 0; k < NO; k++) cfg_fields[k] = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rand_inputs();
    W6END = 12'hA5C;
    #2;
    model_reset();
    n_cmp++; if (RES_I !== 12'hA5C) begin n_err++; $display("FAIL reset_res got %h exp %h", RES_I, 12'hA5C); end
    n_cmp++; if (E6BEG !== {OPA_O, OPA_O, OPA_O}) begin n_err++; $display("FAIL reset_e6 got %h exp %h", E6BEG, {OPA_O, OPA_O, OPA_O}); end
    n_cmp++; if ({cfg_err, cfg_active, CONFout} !== 3'b000) begin n_err++; $display("FAIL reset_status got %b exp 000", {cfg_err, cfg_active, CONFout}); end
    n_cmp++; if (dut_outs !== exp_outs()) begin n_err++; $display("FAIL reset_outs got %h exp %h", dut_outs, exp_outs()); end
    rst = 1'b0;
  endtask

  task automatic test_fixed_wiring();
    for (int t = 0; t < 6; t++) begin
      rand_inputs();
      #1;
      n_cmp++; if (dut_fixed !== exp_fixed()) begin n_err++; $display("FAIL fixed got %h exp %h", dut_fixed, exp_fixed()); end
      n_cmp++; if (dut_outs !== exp_outs()) begin n_err++; $display("FAIL default_outs got %h exp %h", dut_outs, exp_outs()); end
    end
  endtask

  task automatic test_full_load_e2();
    clear_fields();
    for (int k = 0; k < 2*N; k++) cfg_fields[k] = 3'b001;
    OPB_O = 4'b1010;
    shift_stream(CB);
    commit();
    n_cmp++; if (E2BEG !== 8'b1010_1010) begin n_err++; $display("FAIL e2_opb got %h exp aa", E2BEG); end
    n_cmp++; if ({cfg_active, cfg_err} !== 2'b10) begin n_err++; $display("FAIL e2_status got %b exp 10", {cfg_active, cfg_err}); end
    n_cmp++; if (dut_outs !== exp_outs()) begin n_err++; $display("FAIL e2_outs got %h exp %h", dut_outs, exp_outs()); end
  endtask

  task automatic test_short_load();
    clear_fields();
    shift_stream(CB - 1);
    commit();
    n_cmp++; if ({cfg_err, cfg_active} !== 2'b11) begin n_err++; $display("FAIL short_status got %b exp 11", {cfg_err, cfg_active}); end
    n_cmp++; if (E2BEG !== 8'b1010_1010) begin n_err++; $display("FAIL short_keep got %h exp aa", E2BEG); end
    n_cmp++; if (dut_outs !== exp_outs()) begin n_err++; $display("FAIL short_outs got %h exp %h", dut_outs, exp_outs()); end
    for (int k = 0; k < NO; k++) cfg_fields[k] = 3'($urandom_range(0, 7));
    shift_stream(CB);
    commit();
    n_cmp++; if ({cfg_err, cfg_active} !== 2'b01) begin n_err++; $display("FAIL reload_status got %b exp 01", {cfg_err, cfg_active}); end
    n_cmp++; if (dut_outs !== exp_outs()) begin n_err++; $display("FAIL reload_outs got %h exp %h", dut_outs, exp_outs()); end
  endtask

  task automatic test_registered();
    logic v;
    clear_fields();
    cfg_fields[7*N] = 3'b100;
    shift_stream(CB);
    commit();
    tick();
    v = W6END[0];
    W6END[0] = ~v;
    #1;
    n_cmp++; if (RES_I[0] !== v) begin n_err++; $display("FAIL reg_hold got %b exp %b", RES_I[0], v); end
    tick();
    n_cmp++; if (RES_I[0] !== ~v) begin n_err++; $display("FAIL reg_update got %b exp %b", RES_I[0], ~v); end
    clear_fields();
    shift_stream(CB);
    commit();
    v = W6END[0];
    W6END[0] = ~v;
    #1;
    n_cmp++; if (RES_I[0] !== ~v) begin n_err++; $display("FAIL comb_follow got %b exp %b", RES_I[0], ~v); end
    n_cmp++; if (dut_outs !== exp_outs()) begin n_err++; $display("FAIL comb_outs got %h exp %h", dut_outs, exp_outs()); end
  endtask

  task automatic test_shift_commit_together();
    logic exp_tail;
    for (int k = 0; k < NO; k++) cfg_fields[k] = 3'($urandom_range(0, 3));
    shift_stream(CB);
    exp_tail = m_sh[0];
    CONFin = ~exp_tail;
    cfg_shift = 1'b1;
    cfg_commit = 1'b1;
    tick();
    cfg_shift = 1'b0;
    cfg_commit = 1'b0;
    n_cmp++; if (CONFout !== exp_tail) begin n_err++; $display("FAIL both_tail got %b exp %b", CONFout, exp_tail); end
    n_cmp++; if ({cfg_err, cfg_active} !== 2'b01) begin n_err++; $display("FAIL both_status got %b exp 01", {cfg_err, cfg_active}); end
    n_cmp++; if (dut_outs !== exp_outs()) begin n_err++; $display("FAIL both_outs got %h exp %h", dut_outs, exp_outs()); end
  endtask

  task automatic test_reset_mid_shift();
    for (int k = 0; k < NO; k++) cfg_fields[k] = 3'($urandom_range(1, 7));
    shift_stream(60);
    rst = 1'b1;
    #1;
    model_reset();
    n_cmp++; if ({cfg_active, cfg_err, CONFout} !== 3'b000) begin n_err++; $display("FAIL async_rst got %b exp 000", {cfg_active, cfg_err, CONFout}); end
    n_cmp++; if (dut_outs !== exp_outs()) begin n_err++; $display("FAIL async_outs got %h exp %h", dut_outs, exp_outs()); end
    rst = 1'b0;
    commit();
    n_cmp++; if ({cfg_err, cfg_active} !== 2'b10) begin n_err++; $display("FAIL rst_commit got %b exp 10", {cfg_err, cfg_active}); end
    n_cmp++; if (RES_I !== W6END) begin n_err++; $display("FAIL rst_default got %h exp %h", RES_I, W6END); end
    n_cmp++; if (dut_outs !== exp_outs()) begin n_err++; $display("FAIL rst_outs got %h exp %h", dut_outs, exp_outs()); end
  endtask

  task automatic test_random();
    int n_sh, b;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < NO; k++) cfg_fields[k] = 3'($urandom_range(0, 7));
      n_sh = (it % 4 == 3) ? CB + 5 : ((it % 4 == 2) ? CB - 1 - $urandom_range(0, 10) : CB);
      for (int j = 0; j < n_sh; j++) begin
        b = (CB - 1 - j) % CB;
        CONFin = cfg_fields[b/3][b%3];
        cfg_shift = 1'b1;
        if ($urandom_range(0, 7) == 0) rand_inputs();
        tick();
        if (j % 30 == 7) begin
          n_cmp++; if (CONFout !== m_sh[0]) begin n_err++; $display("FAIL rnd_tail got %b exp %b", CONFout, m_sh[0]); end
        end
      end
      cfg_shift = 1'b0;
      commit();
      n_cmp++; if ({cfg_err, cfg_active} !== {m_err, m_act}) begin n_err++; $display("FAIL rnd_status got %b exp %b", {cfg_err, cfg_active}, {m_err, m_act}); end
      for (int c = 0; c < 10; c++) begin
        rand_inputs();
        #1;
        n_cmp++; if (dut_outs !== exp_outs()) begin n_err++; $display("FAIL rnd_comb got %h exp %h", dut_outs, exp_outs()); end
        tick();
        n_cmp++; if (dut_outs !== exp_outs()) begin n_err++; $display("FAIL rnd_edge got %h exp %h", dut_outs, exp_outs()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_wiring();
    test_full_load_e2();
    test_short_load();
    test_registered();
    test_shift_commit_together();
    test_reset_mid_shift();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
